// File: rtl/ram_controller_if.sv
// ----------------------------------------------------------------------------
// ram_controller_if
// Request/response bundle between the DataPath/ControlUnit and the data-memory
// controller.
//   RAM_enable  : request strobe, sampled only while the controller is not busy
//   RAM_OpCode  : SPARC op3 of the access
//   address     : byte address of the access
//   data_in     : store data ({word@addr, word@addr+4} for doubleword stores)
//   data_out    : load result ({word@addr, word@addr+4} for doubleword loads)
//   MFC         : one-cycle completion pulse
//   misaligned  : one-cycle alignment-fault pulse
//   busy        : request in progress, new requests are ignored
// Modports: master drives requests (DataPath side), slave is the controller.
// ----------------------------------------------------------------------------
interface ram_controller_if #(
  parameter int ADDR_WIDTH = 9
);

  logic                  RAM_enable;
  logic [5:0]            RAM_OpCode;
  logic [ADDR_WIDTH-1:0] address;
  logic [63:0]           data_in;
  logic [63:0]           data_out;
  logic                  MFC;
  logic                  misaligned;
  logic                  busy;

  modport master (
    output RAM_enable, RAM_OpCode, address, data_in,
    input  data_out, MFC, misaligned, busy
  );

  modport slave (
    input  RAM_enable, RAM_OpCode, address, data_in,
    output data_out, MFC, misaligned, busy
  );

endinterface

// File: rtl/ram_controller.sv
// ----------------------------------------------------------------------------
// ram_controller
// Multi-cycle SPARC V8 data-memory controller with an internal big-endian,
// byte-addressed array. Supports byte/halfword/word/doubleword accesses with
// sign or zero extension, configurable wait states per 32-bit beat, alignment
// fault detection and an MFC completion handshake.
// Ports:
//   Clk      : rising-edge clock
//   RESET_n  : asynchronous active-low reset (array contents are kept)
//   bus      : ram_controller_if.slave, request/response bundle
// Parameters:
//   ADDR_WIDTH  : byte-address width, array holds 2**ADDR_WIDTH bytes
//   WAIT_CYCLES : wait states per 32-bit beat (0..15)
// ----------------------------------------------------------------------------
module ram_controller #(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          Clk,
  input  logic          RESET_n,
  ram_controller_if.slave bus
);

  localparam logic [5:0] OP_LD   = 6'b000000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_LDD  = 6'b000011;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;
  localparam logic [5:0] OP_STD  = 6'b000111;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, FAULT} state_t;

  state_t                state_q, state_d;
  logic [5:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [63:0]           din_q, din_d;
  logic                  beat_q, beat_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [63:0]           dout_q, dout_d;
  logic                  mfc_q, mfc_d;
  logic                  mis_q, mis_d;
  logic                  busy_q, busy_d;

  logic [7:0]            mem [0:(1 << ADDR_WIDTH) - 1];

  logic                  alignFault;
  logic                  isDouble;
  logic                  beatNow;
  logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
  logic [31:0]           rdWord;
  logic [31:0]           storeWord;
  logic [63:0]           loadVal;

  // Byte lanes of the current beat. The second beat of a doubleword sits one
  // word above the latched address; byte 0 is the most significant (big-endian).
  assign a0        = beat_q ? addr_q + ADDR_WIDTH'(4) : addr_q;
  assign a1        = a0 + ADDR_WIDTH'(1);
  assign a2        = a0 + ADDR_WIDTH'(2);
  assign a3        = a0 + ADDR_WIDTH'(3);
  assign rdWord    = {mem[a0], mem[a1], mem[a2], mem[a3]};
  assign beatNow   = (state_q == WAIT) && (cnt_q == 4'd0);
  assign isDouble  = (op_q == OP_LDD) || (op_q == OP_STD);
  assign storeWord = (op_q == OP_STD && !beat_q) ? din_q[63:32] : din_q[31:0];

  // Alignment check on the incoming request: halfwords need an even address,
  // words a multiple of 4, doublewords a multiple of 8. Other opcodes never
  // fault.
  always_comb begin
    alignFault = 1'b0;
    case (bus.RAM_OpCode)
      OP_LDUH, OP_LDSH, OP_STH: alignFault = bus.address[0];
      OP_LD, OP_ST:             alignFault = |bus.address[1:0];
      OP_LDD, OP_STD:           alignFault = |bus.address[2:0];
      default:                  alignFault = 1'b0;
    endcase
  end

  // Value data_out takes on a beat edge. Non-load opcodes keep the old value,
  // which is how stores and unlisted opcodes leave data_out untouched. The
  // doubleword load fills the upper word on beat 0 and the lower on beat 1.
  always_comb begin
    loadVal = dout_q;
    case (op_q)
      OP_LD:   loadVal = {32'd0, rdWord};
      OP_LDUB: loadVal = {56'd0, mem[a0]};
      OP_LDSB: loadVal = {32'd0, {24{mem[a0][7]}}, mem[a0]};
      OP_LDUH: loadVal = {48'd0, mem[a0], mem[a1]};
      OP_LDSH: loadVal = {32'd0, {16{mem[a0][7]}}, mem[a0], mem[a1]};
      OP_LDD:  loadVal = beat_q ? {dout_q[63:32], rdWord} : {rdWord, dout_q[31:0]};
      default: loadVal = dout_q;
    endcase
  end

  // Next-state logic. A request is only looked at in IDLE with busy low, so a
  // request raised during the MFC cycle waits one more cycle. busy covers
  // everything from acceptance up to and including the MFC cycle, which is the
  // cycle after DONE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    din_d   = din_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    mis_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.RAM_enable && !busy_q) begin
          if (alignFault) begin
            state_d = FAULT;
            mis_d   = 1'b1;
          end else begin
            op_d    = bus.RAM_OpCode;
            addr_d  = bus.address;
            din_d   = bus.data_in;
            beat_d  = 1'b0;
            cnt_d   = WAIT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          dout_d = loadVal;
          if (isDouble && !beat_q) begin
            beat_d = 1'b1;
            cnt_d  = WAIT_LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mfc_d  = (state_q == DONE);
    busy_d = (state_d != IDLE) || (state_q == DONE);
  end

  // State and output registers. Reset aborts any access in flight; because the
  // array write depends on state_q, a beat not yet performed never writes.
  always_ff @(posedge Clk or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= IDLE;
      op_q    <= 6'd0;
      addr_q  <= '0;
      din_q   <= 64'd0;
      beat_q  <= 1'b0;
      cnt_q   <= 4'd0;
      dout_q  <= 64'd0;
      mfc_q   <= 1'b0;
      mis_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      mfc_q   <= mfc_d;
      mis_q   <= mis_d;
      busy_q  <= busy_d;
    end
  end

  // Array write port. Only the addressed bytes are written; the array is not
  // reset so that stored data survives a controller reset.
  always_ff @(posedge Clk) begin
    if (beatNow) begin
      case (op_q)
        OP_ST, OP_STD: begin
          mem[a0] <= storeWord[31:24];
          mem[a1] <= storeWord[23:16];
          mem[a2] <= storeWord[15:8];
          mem[a3] <= storeWord[7:0];
        end
        OP_STH: begin
          mem[a0] <= storeWord[15:8];
          mem[a1] <= storeWord[7:0];
        end
        OP_STB: begin
          mem[a0] <= storeWord[7:0];
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.data_out   = dout_q;
  assign bus.MFC        = mfc_q;
  assign bus.misaligned = mis_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_ram_controller.sv
// ----------------------------------------------------------------------------
// tb_ram_controller
// Directed bench for ram_controller (ADDR_WIDTH=9, WAIT_CYCLES=2). A table of
// accesses with hand-computed latencies, pulse counts and load results, plus
// hand-written sequences for request-while-busy and reset during a doubleword
// store.
// ----------------------------------------------------------------------------
module tb_ram_controller;

  localparam logic [5:0] OP_LD   = 6'b000000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_LDD  = 6'b000011;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;
  localparam logic [5:0] OP_STD  = 6'b000111;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;
  localparam logic [5:0] OP_NOP  = 6'b111111;

  // Event cycle = number of clock edges after the accepting edge at which the
  // MFC (or misaligned) pulse is observed.
  localparam int LAT_SINGLE = 4;
  localparam int LAT_DOUBLE = 7;
  localparam int LAT_FAULT  = 0;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [8:0]  addr;
    logic [63:0] din;
    logic        expMis;
    int          expLat;
    logic [63:0] expOut;
  } vec_t;

  logic Clk;
  logic RESET_n;
  int   checks;
  int   errors;
  vec_t vecs[$];

  ram_controller_if #(.ADDR_WIDTH(9)) bus ();

  ram_controller #(
    .ADDR_WIDTH (9),
    .WAIT_CYCLES(2)
  ) dut (
    .Clk    (Clk),
    .RESET_n(RESET_n),
    .bus    (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One comparison: counts it, reports a mismatch.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
    end
  endtask

  task automatic addVec(input string name, input logic [5:0] op, input int addr,
                        input logic [63:0] din, input logic expMis, input int expLat,
                        input logic [63:0] expOut);
    vec_t v;
    v.name   = name;
    v.op     = op;
    v.addr   = 9'(addr);
    v.din    = din;
    v.expMis = expMis;
    v.expLat = expLat;
    v.expOut = expOut;
    vecs.push_back(v);
  endtask

  // Present one request (called just after a rising edge with busy low), then
  // watch the response until busy drops, with a bounded cycle budget.
  task automatic applyStimulus(input logic [5:0] op, input logic [8:0] addr,
                               input logic [63:0] din, output int lat,
                               output int mfcCnt, output int misCnt,
                               output int busyGap);
    bus.RAM_OpCode = op;
    bus.address    = addr;
    bus.data_in    = din;
    bus.RAM_enable = 1'b1;
    @(posedge Clk); #1;
    bus.RAM_enable = 1'b0;
    lat     = -1;
    mfcCnt  = 0;
    misCnt  = 0;
    busyGap = 0;
    for (int j = 0; j <= 40; j++) begin
      if (bus.MFC) begin
        mfcCnt++;
        if (lat < 0) lat = j;
      end
      if (bus.misaligned) begin
        misCnt++;
        if (lat < 0) lat = j;
      end
      if (!bus.busy) begin
        if (lat < 0) busyGap = 1;
        break;
      end
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat, mfcCnt, misCnt, busyGap;
    checks = 0;
    errors = 0;

    // Stimulus table: data_out expectation is the value after the access.
    addVec("ST @32",        OP_ST,   32, 64'h12345678, 1'b0, LAT_SINGLE, 64'h0);
    addVec("LD @32",        OP_LD,   32, 64'h0,        1'b0, LAT_SINGLE, 64'h12345678);
    addVec("LDUB @33",      OP_LDUB, 33, 64'h0,        1'b0, LAT_SINGLE, 64'h34);
    addVec("LDUH @34",      OP_LDUH, 34, 64'h0,        1'b0, LAT_SINGLE, 64'h5678);
    addVec("STB @40",       OP_STB,  40, 64'h80,       1'b0, LAT_SINGLE, 64'h5678);
    addVec("LDSB @40",      OP_LDSB, 40, 64'h0,        1'b0, LAT_SINGLE, 64'hFFFFFF80);
    addVec("LDUB @40",      OP_LDUB, 40, 64'h0,        1'b0, LAT_SINGLE, 64'h80);
    addVec("STH @34",       OP_STH,  34, 64'hBEEF,     1'b0, LAT_SINGLE, 64'h80);
    addVec("LD @32 after STH", OP_LD, 32, 64'h0,       1'b0, LAT_SINGLE, 64'h1234BEEF);
    addVec("STH @44",       OP_STH,  44, 64'h8001,     1'b0, LAT_SINGLE, 64'h1234BEEF);
    addVec("LDSH @44",      OP_LDSH, 44, 64'h0,        1'b0, LAT_SINGLE, 64'hFFFF8001);
    addVec("LDUH @44",      OP_LDUH, 44, 64'h0,        1'b0, LAT_SINGLE, 64'h8001);
    addVec("STD @48",       OP_STD,  48, 64'hAAAA0001_55550002, 1'b0, LAT_DOUBLE, 64'h8001);
    addVec("LDD @48",       OP_LDD,  48, 64'h0,        1'b0, LAT_DOUBLE, 64'hAAAA0001_55550002);
    addVec("LD @52",        OP_LD,   52, 64'h0,        1'b0, LAT_SINGLE, 64'h55550002);
    addVec("LD @33 fault",  OP_LD,   33, 64'h0,        1'b1, LAT_FAULT,  64'h55550002);
    addVec("LDUH @41 fault", OP_LDUH, 41, 64'h0,       1'b1, LAT_FAULT,  64'h55550002);
    addVec("LDD @36 fault", OP_LDD,  36, 64'h0,        1'b1, LAT_FAULT,  64'h55550002);
    addVec("ST @34 fault",  OP_ST,   34, 64'hDEADDEAD, 1'b1, LAT_FAULT,  64'h55550002);
    addVec("LDUB @33 again", OP_LDUB, 33, 64'h0,       1'b0, LAT_SINGLE, 64'h34);
    addVec("unlisted op @32", OP_NOP, 32, 64'hDEADDEAD, 1'b0, LAT_SINGLE, 64'h34);
    addVec("LD @32 after faults", OP_LD, 32, 64'h0,    1'b0, LAT_SINGLE, 64'h1234BEEF);
    addVec("ST @60",        OP_ST,   60, 64'h60606060, 1'b0, LAT_SINGLE, 64'h1234BEEF);

    // Reset state
    RESET_n        = 1'b0;
    bus.RAM_enable = 1'b0;
    bus.RAM_OpCode = 6'd0;
    bus.address    = 9'd0;
    bus.data_in    = 64'd0;
    repeat (2) @(posedge Clk);
    #1;
    checkOutput("reset data_out", bus.data_out, 64'h0);
    checkOutput("reset MFC", {63'd0, bus.MFC}, 64'h0);
    checkOutput("reset misaligned", {63'd0, bus.misaligned}, 64'h0);
    checkOutput("reset busy", {63'd0, bus.busy}, 64'h0);
    RESET_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      checkOutput("idle data_out", bus.data_out, 64'h0);
      checkOutput("idle flags", {61'd0, bus.MFC, bus.misaligned, bus.busy}, 64'h0);
    end

    // Table-driven accesses
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].din, lat, mfcCnt, misCnt, busyGap);
      checkOutput({vecs[i].name, " event cycle"}, 64'(lat), 64'(vecs[i].expLat));
      checkOutput({vecs[i].name, " MFC pulses"}, 64'(mfcCnt), vecs[i].expMis ? 64'd0 : 64'd1);
      checkOutput({vecs[i].name, " misaligned pulses"}, 64'(misCnt), vecs[i].expMis ? 64'd1 : 64'd0);
      checkOutput({vecs[i].name, " busy gap"}, 64'(busyGap), 64'd0);
      checkOutput({vecs[i].name, " data_out"}, bus.data_out, vecs[i].expOut);
    end

    // RAM_enable toggled while busy: ignored, exactly one completion.
    bus.RAM_OpCode = OP_LD;
    bus.address    = 9'd32;
    bus.data_in    = 64'd0;
    bus.RAM_enable = 1'b1;
    @(posedge Clk); #1;
    mfcCnt = 0;
    for (int j = 0; j < 16; j++) begin
      if (bus.MFC) mfcCnt++;
      bus.RAM_enable = (j < 3) ? ~bus.RAM_enable : 1'b0;
      @(posedge Clk); #1;
    end
    checkOutput("toggle MFC pulses", 64'(mfcCnt), 64'd1);
    checkOutput("toggle data_out", bus.data_out, 64'h1234BEEF);
    checkOutput("toggle busy after", {63'd0, bus.busy}, 64'h0);

    // Reset during beat-1 wait of STD @56: word@56 written, word@60 kept.
    bus.RAM_OpCode = OP_STD;
    bus.address    = 9'd56;
    bus.data_in    = 64'hCAFE0056_BEEF0060;
    bus.RAM_enable = 1'b1;
    @(posedge Clk); #1;
    bus.RAM_enable = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    RESET_n = 1'b0;
    #1;
    checkOutput("mid-reset data_out", bus.data_out, 64'h0);
    checkOutput("mid-reset flags", {61'd0, bus.MFC, bus.misaligned, bus.busy}, 64'h0);
    repeat (2) @(posedge Clk);
    #1;
    RESET_n = 1'b1;
    mfcCnt = 0;
    for (int j = 0; j < 4; j++) begin
      @(posedge Clk); #1;
      if (bus.MFC || bus.busy) mfcCnt++;
    end
    checkOutput("post-reset activity", 64'(mfcCnt), 64'd0);
    checkOutput("post-reset data_out", bus.data_out, 64'h0);
    applyStimulus(OP_LD, 9'd56, 64'h0, lat, mfcCnt, misCnt, busyGap);
    checkOutput("LD @56 event cycle", 64'(lat), 64'(LAT_SINGLE));
    checkOutput("LD @56 data_out", bus.data_out, 64'hCAFE0056);
    applyStimulus(OP_LD, 9'd60, 64'h0, lat, mfcCnt, misCnt, busyGap);
    checkOutput("LD @60 event cycle", 64'(lat), 64'(LAT_SINGLE));
    checkOutput("LD @60 data_out", bus.data_out, 64'h60606060);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_controller.md
# ram_controller

Parametrised, multi-cycle SPARC V8 data-memory controller with an internal big-endian byte-addressed array. It sits between the DataPath (MAR/MDR) and memory, replacing the fixed-width single-cycle RAM. It adds configurable wait states, byte/halfword/word/doubleword accesses with sign or zero extension, alignment-fault detection, and an MFC completion handshake the ControlUnit can stall on.

## Interface
- ADDR_WIDTH, 9: byte-address width; array holds 2^ADDR_WIDTH bytes.
- WAIT_CYCLES, 2: wait states per 32-bit beat, legal range 0..15.

- Clk  in  1  rising-edge clock.
- RESET_n  in  1  asynchronous, active-low reset.
- RAM_enable  in  1  request strobe; sampled only when busy=0.
- RAM_OpCode  in  6  SPARC op3: LD 000000, LDUB 000001, LDUH 000010, LDD 000011, ST 000100, STB 000101, STH 000110, STD 000111, LDSB 001001, LDSH 001010.
- address  in  ADDR_WIDTH  byte address of the access.
- data_in  in  64  store data: [31:0] for ST/STH/STB (low bits used); {word@addr, word@addr+4} = [63:32],[31:0] for STD.
- data_out  out  64  load result: [31:0] for single loads, upper 32 bits zero; LDD gives word@addr in [63:32], word@addr+4 in [31:0].
- MFC  out  1  one-cycle completion pulse.
- misaligned  out  1  one-cycle alignment-fault pulse; the ControlUnit maps it to trap tt.
- busy  out  1  high from the cycle after acceptance through the MFC/misaligned cycle.

## Operation
- States: IDLE, WAIT, DONE, FAULT.
- IDLE with RAM_enable=1 runs an alignment check:
  - Halfword ops require address[0]=0.
  - Word ops require address[1:0]=0.
  - LDD/STD require address[2:0]=0.
- On a failed check: go to FAULT. No array access and no MFC. Next state is IDLE.
- On a passed check: latch opcode, address and data_in; beat=0; counter=WAIT_CYCLES; go to WAIT.
- WAIT:
  - If counter≠0, decrement it.
  - If counter=0, perform the beat access on this edge at address + 4·beat.
  - For LDD/STD with beat=0, then set beat=1, reload the counter and stay in WAIT. Otherwise go to DONE.
- DONE: MFC=1 for exactly one cycle, then return to IDLE.
- Byte order is big-endian: byte[a] is the MSB.
  - LDUB and LDUH zero-extend.
  - LDSB and LDSH sign-extend from bit 7 and bit 15 respectively.
  - STB/STH write only the addressed bytes.
- Loads update data_out at the beat edge. data_out holds its value until the next load beat; stores do not alter it.
- Unlisted opcodes complete as no-ops: normal latency and MFC, no array write, data_out unchanged.
- RAM_enable while busy=1 is ignored and not queued.
- An 8-aligned doubleword never straddles the top of the array. Word addresses never wrap.

## Timing
- Reset values: state IDLE; MFC=0, misaligned=0, busy=0, data_out=0; beat=0, counter=0. Array contents are not cleared.
- Reset asserted mid-operation aborts immediately. Any beat not yet performed never writes. For STD, a completed beat 0 stays written and beat 1 does not.
- Request accepted at edge k:
  - busy rises after edge k.
  - Single-beat MFC is high in the cycle after edge k+WAIT_CYCLES+2.
  - Doubleword MFC is high in the cycle after edge k+2·WAIT_CYCLES+3.
- Misaligned request at edge k: misaligned and busy are high for the cycle after edge k. Back in IDLE after edge k+1.
- A new request may be presented in the MFC cycle. It is accepted on the edge that leaves DONE only if busy is low at that edge; with the registered busy, that is the following cycle.
- With WAIT_CYCLES=0, a single access completes its beat on edge k+1, and MFC is high after edge k+2.

## Test plan
- Reset: hold RESET_n=0 → data_out=0, MFC=0, misaligned=0, busy=0. Release, then idle 5 cycles → all outputs unchanged.
- ST 0x12345678 @32 (WAIT_CYCLES=2) → MFC one cycle after edge k+4. Then:
  - LD @32 → 0x12345678.
  - LDUB @33 → 0x00000034.
  - LDUH @34 → 0x00005678.
- STB 0x80 @40 then LDSB @40 → 0xFFFFFF80; LDUB @40 → 0x00000080. STH 0xBEEF @34 then LD @32 → 0x1234BEEF.
- STD {0xAAAA0001,0x55550002} @48 → busy high continuously, MFC after edge k+7. Then:
  - LDD @48 → data_out=0xAAAA000155550002.
  - LD @52 → 0x55550002.
- LD @33, LDH @41, LDD @36 → misaligned pulse one cycle after acceptance, no MFC, memory unchanged (verify with LD @32).
- STD @56 with RESET_n pulsed low during beat-1 WAIT → word@56 written, word@60 unchanged, outputs all zero. Separately, RAM_enable toggled while busy → ignored, exactly one MFC.
